// File: rtl/csi2_tx_pkg.sv
// rtl/csi2_tx_pkg.sv - shared types and defaults for the CSI-2 TX frame path
package csi2_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_FS       = 3'd1,
        ST_FWD      = 3'd2,
        ST_WAIT_REP = 3'd3,
        ST_LGAP     = 3'd4,
        ST_FE       = 3'd5,
        ST_FGAP     = 3'd6
    } seq_state_t;

    typedef enum logic {
        SRC_LIVE    = 1'b0,
        SRC_PATTERN = 1'b1
    } src_t;

    localparam int DEF_WORDS_PER_LINE = 256;

endpackage

// File: rtl/csi2_tx_gap_timer.sv
// rtl/csi2_tx_gap_timer.sv - loadable down-counter timing line and frame blanking
module csi2_tx_gap_timer
    import csi2_tx_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] value_i,
    output logic         expired_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = value_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Loaded with N on the entry edge, so the last of N gap cycles sees 1.
    assign expired_o = (cnt_q == W'(1));

endmodule

// File: rtl/csi2_tx_frame_sequencer.sv
// rtl/csi2_tx_frame_sequencer.sv - frame/line sequencer feeding the CSI-2 TX line repeater
module csi2_tx_frame_sequencer
    import csi2_tx_pkg::*;
#(
    parameter int LINES_PER_FRAME  = 16,
    parameter int WORDS_PER_LINE   = DEF_WORDS_PER_LINE,
    parameter int LINE_GAP_CYCLES  = 32,
    parameter int FRAME_GAP_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        src_sel,
    input  logic [15:0] s0_axis_tdata,
    input  logic        s0_axis_tvalid,
    input  logic        s0_axis_tlast,
    output logic        s0_axis_tready,
    input  logic [15:0] s1_axis_tdata,
    input  logic        s1_axis_tvalid,
    input  logic        s1_axis_tlast,
    output logic        s1_axis_tready,
    output logic [15:0] m_axis_tdata,
    output logic        m_axis_tvalid,
    output logic        m_axis_tlast,
    output logic        m_axis_tuser,
    input  logic        m_axis_tready,
    input  logic        rep_done,
    output logic        fs_req,
    output logic        fe_req,
    input  logic        fs_ack,
    input  logic        fe_ack,
    output logic        busy,
    output logic        src_active,
    output logic [15:0] frame_count,
    output logic        len_err
);

    localparam int WC_W    = (WORDS_PER_LINE > 1) ? $clog2(WORDS_PER_LINE) : 1;
    localparam int LC_W    = $clog2(LINES_PER_FRAME + 1);
    localparam int GAP_MAX = (LINE_GAP_CYCLES > FRAME_GAP_CYCLES) ? LINE_GAP_CYCLES : FRAME_GAP_CYCLES;
    localparam int GAP_W   = (GAP_MAX > 0) ? $clog2(GAP_MAX + 1) : 1;

    seq_state_t      state_q;
    src_t            src_active_q;
    logic [WC_W-1:0] word_cnt_q;
    logic [LC_W-1:0] line_cnt_q;
    logic [LC_W-1:0] line_cnt_d;
    logic            fs_req_q;
    logic            fe_req_q;
    logic            busy_q;
    logic            len_err_q;
    logic [15:0]     frame_count_q;

    logic             fwd;
    logic [15:0]      sel_tdata;
    logic             sel_tvalid;
    logic             sel_tlast;
    logic             last_word;
    logic             beat;
    logic             gap_load;
    logic [GAP_W-1:0] gap_value;
    logic             gap_expired;

    always_comb begin
        sel_tdata  = s0_axis_tdata;
        sel_tvalid = s0_axis_tvalid;
        sel_tlast  = s0_axis_tlast;
        if (src_active_q == SRC_PATTERN) begin
            sel_tdata  = s1_axis_tdata;
            sel_tvalid = s1_axis_tvalid;
            sel_tlast  = s1_axis_tlast;
        end
    end

    assign fwd        = (state_q == ST_FWD);
    assign last_word  = (word_cnt_q == WC_W'(WORDS_PER_LINE - 1));
    assign beat       = fwd && sel_tvalid && m_axis_tready;
    assign line_cnt_d = line_cnt_q + 1'b1;

    // A zero-length gap never loads the timer; the FSM bypasses the gap state instead.
    assign gap_load  = ((state_q == ST_WAIT_REP) && rep_done && (LINE_GAP_CYCLES != 0)) ||
                       ((state_q == ST_FE) && fe_ack && (FRAME_GAP_CYCLES != 0));
    assign gap_value = (state_q == ST_FE) ? GAP_W'(FRAME_GAP_CYCLES) : GAP_W'(LINE_GAP_CYCLES);

    csi2_tx_gap_timer #(
        .W (GAP_W)
    ) u_gap_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_i    (gap_load),
        .value_i   (gap_value),
        .expired_o (gap_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            src_active_q  <= SRC_LIVE;
            word_cnt_q    <= '0;
            line_cnt_q    <= '0;
            fs_req_q      <= 1'b0;
            fe_req_q      <= 1'b0;
            busy_q        <= 1'b0;
            len_err_q     <= 1'b0;
            frame_count_q <= '0;
        end else begin
            len_err_q <= beat && (sel_tlast != last_word);
            case (state_q)
                ST_IDLE: if (enable) begin
                    src_active_q <= src_t'(src_sel);
                    line_cnt_q   <= '0;
                    word_cnt_q   <= '0;
                    fs_req_q     <= 1'b1;
                    busy_q       <= 1'b1;
                    state_q      <= ST_FS;
                end
                ST_FS: if (fs_ack) begin
                    fs_req_q <= 1'b0;
                    state_q  <= ST_FWD;
                end
                ST_FWD: if (beat) begin
                    if (last_word) begin
                        word_cnt_q <= '0;
                        state_q    <= ST_WAIT_REP;
                    end else begin
                        word_cnt_q <= word_cnt_q + 1'b1;
                    end
                end
                ST_WAIT_REP: if (rep_done) begin
                    line_cnt_q <= line_cnt_d;
                    if (LINE_GAP_CYCLES != 0) begin
                        state_q <= ST_LGAP;
                    end else if (line_cnt_d == LC_W'(LINES_PER_FRAME)) begin
                        fe_req_q <= 1'b1;
                        state_q  <= ST_FE;
                    end else begin
                        state_q <= ST_FWD;
                    end
                end
                ST_LGAP: if (gap_expired) begin
                    if (line_cnt_q == LC_W'(LINES_PER_FRAME)) begin
                        fe_req_q <= 1'b1;
                        state_q  <= ST_FE;
                    end else begin
                        state_q <= ST_FWD;
                    end
                end
                ST_FE: if (fe_ack) begin
                    fe_req_q      <= 1'b0;
                    frame_count_q <= frame_count_q + 16'd1;
                    if (FRAME_GAP_CYCLES != 0) begin
                        state_q <= ST_FGAP;
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                ST_FGAP: if (gap_expired) begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign m_axis_tdata   = fwd ? sel_tdata : '0;
    assign m_axis_tvalid  = fwd && sel_tvalid;
    assign m_axis_tlast   = fwd && last_word;
    assign m_axis_tuser   = fwd && (line_cnt_q == '0) && (word_cnt_q == '0);
    assign s0_axis_tready = fwd && (src_active_q == SRC_LIVE) && m_axis_tready;
    assign s1_axis_tready = fwd && (src_active_q == SRC_PATTERN) && m_axis_tready;
    assign fs_req         = fs_req_q;
    assign fe_req         = fe_req_q;
    assign busy           = busy_q;
    assign src_active     = src_active_q;
    assign frame_count    = frame_count_q;
    assign len_err        = len_err_q;

endmodule

// File: tb/tb_csi2_tx_frame_sequencer.sv
// tb/tb_csi2_tx_frame_sequencer.sv - self-checking bench for csi2_tx_frame_sequencer
module tb_csi2_tx_frame_sequencer;

    localparam int LPF   = 4;
    localparam int WPL   = 8;
    localparam int LG    = 3;
    localparam int FG    = 5;
    localparam int LIMIT = 3000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        src_sel = 1'b0;
    logic [15:0] s0_tdata = '0, s1_tdata = '0;
    logic        s0_tvalid = 1'b0, s0_tlast = 1'b0, s1_tvalid = 1'b0, s1_tlast = 1'b0;
    logic        s0_tready, s1_tready;
    logic [15:0] m_tdata;
    logic        m_tvalid, m_tlast, m_tuser;
    logic        m_tready = 1'b0;
    logic        rep_done = 1'b0, fs_ack = 1'b0, fe_ack = 1'b0;
    logic        fs_req, fe_req, busy, src_active, len_err;
    logic [15:0] frame_count;

    always #5 clk = ~clk;

    csi2_tx_frame_sequencer #(
        .LINES_PER_FRAME  (LPF),
        .WORDS_PER_LINE   (WPL),
        .LINE_GAP_CYCLES  (LG),
        .FRAME_GAP_CYCLES (FG)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .enable         (enable),
        .src_sel        (src_sel),
        .s0_axis_tdata  (s0_tdata),
        .s0_axis_tvalid (s0_tvalid),
        .s0_axis_tlast  (s0_tlast),
        .s0_axis_tready (s0_tready),
        .s1_axis_tdata  (s1_tdata),
        .s1_axis_tvalid (s1_tvalid),
        .s1_axis_tlast  (s1_tlast),
        .s1_axis_tready (s1_tready),
        .m_axis_tdata   (m_tdata),
        .m_axis_tvalid  (m_tvalid),
        .m_axis_tlast   (m_tlast),
        .m_axis_tuser   (m_tuser),
        .m_axis_tready  (m_tready),
        .rep_done       (rep_done),
        .fs_req         (fs_req),
        .fe_req         (fe_req),
        .fs_ack         (fs_ack),
        .fe_ack         (fe_ack),
        .busy           (busy),
        .src_active     (src_active),
        .frame_count    (frame_count),
        .len_err        (len_err)
    );

    int n_checks = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Knobs owned by the main sequence.
    logic rnd_mode = 1'b0;
    logic inject = 1'b0;

    // Reference model state, owned by the monitor.
    logic        model_active = 1'b0;
    int          li = 0, bi = 0;
    int          m_n [2] = '{0, 0};
    logic [15:0] model_fc = '0;
    logic [15:0] exp_data;
    logic        exp_len_err = 1'b0;
    logic        prev_fs = 1'b0, prev_fe = 1'b0, prev_fs_hs = 1'b0, prev_fe_hs = 1'b0, prev_sel = 1'b0;
    logic        acc0 = 1'b0, acc1 = 1'b0, tlast_acc = 1'b0;
    logic        selv, selr, selt;
    int          fs_rises = 0, fe_rises = 0, beats = 0, tlast_cnt = 0, tuser_cnt = 0, len_err_cnt = 0;
    logic [15:0] last_data = '0;
    logic        last_tuser = 1'b0;
    int          line_gap_first = -1, frame_gap_first = -1;
    int          since_rep = 0, since_fe = 0;
    logic        rep_armed = 1'b0, fe_armed = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            model_active = 1'b0; li = 0; bi = 0; model_fc = '0; exp_len_err = 1'b0;
            prev_fs = 1'b0; prev_fe = 1'b0; prev_fs_hs = 1'b0; prev_fe_hs = 1'b0;
            acc0 = 1'b0; acc1 = 1'b0; tlast_acc = 1'b0; rep_armed = 1'b0; fe_armed = 1'b0;
        end else begin
            if (rep_armed) since_rep++;
            if (fe_armed) since_fe++;
            if (fs_req && !prev_fs) begin
                fs_rises++;
                model_active = prev_sel;
                li = 0;
                bi = 0;
                if (fe_armed && frame_gap_first < 0) frame_gap_first = since_fe;
                fe_armed = 1'b0;
            end
            if (fe_req && !prev_fe) fe_rises++;
            if (prev_fs_hs) chk("fs_req_drop", fs_req, 0);
            if (prev_fe_hs) begin
                chk("fe_req_drop", fe_req, 0);
                model_fc = model_fc + 16'd1;
            end
            chk("frame_count", frame_count, model_fc);
            chk("src_active", src_active, model_active);
            chk("len_err", len_err, exp_len_err);
            if (len_err) len_err_cnt++;
            selv = model_active ? s1_tvalid : s0_tvalid;
            selr = model_active ? s1_tready : s0_tready;
            selt = model_active ? s1_tlast : s0_tlast;
            chk("unsel_tready", model_active ? s0_tready : s1_tready, 0);
            chk("xfer", m_tvalid && m_tready, selv && selr);
            if (fs_req || fe_req || m_tvalid) chk("busy", busy, 1);
            exp_len_err = 1'b0;
            tlast_acc = 1'b0;
            if (m_tvalid && m_tready) begin
                exp_data = (model_active ? 16'hA000 : 16'h1000) + 16'(m_n[model_active]);
                chk("tdata", m_tdata, exp_data);
                chk("tlast", m_tlast, bi == WPL - 1);
                chk("tuser", m_tuser, li == 0 && bi == 0);
                exp_len_err = (selt != (bi == WPL - 1));
                m_n[model_active]++;
                beats++;
                last_data = m_tdata;
                last_tuser = m_tuser;
                if (m_tuser) tuser_cnt++;
                if (bi == WPL - 1) begin
                    tlast_cnt++;
                    tlast_acc = 1'b1;
                end
                if (rep_armed && line_gap_first < 0) line_gap_first = since_rep;
                rep_armed = 1'b0;
                bi++;
                if (bi == WPL) begin
                    bi = 0;
                    li = (li + 1) % LPF;
                end
            end
            if (rep_done) begin
                since_rep = 0;
                rep_armed = 1'b1;
            end
            if (fe_req && fe_ack) begin
                since_fe = 0;
                fe_armed = 1'b1;
            end
            prev_fs_hs = fs_req && fs_ack;
            prev_fe_hs = fe_req && fe_ack;
            prev_fs = fs_req;
            prev_fe = fe_req;
            acc0 = s0_tvalid && s0_tready;
            acc1 = s1_tvalid && s1_tready;
        end
        prev_sel = src_sel;
    end

    // Environment: sources, repeater done pulses, packetizer acks, sink readiness.
    int rep_cd = 0, fs_cnt = 0, fe_cnt = 0, n0 = 0, n1 = 0;

    always @(posedge clk) begin
        #1;
        m_tready = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        if (!rst_n) begin
            rep_cd = 0; rep_done = 1'b0; fs_ack = 1'b0; fe_ack = 1'b0; fs_cnt = 0; fe_cnt = 0;
        end else begin
            if (tlast_acc) rep_cd = 20;
            else if (rep_cd != 0) rep_cd--;
            rep_done = (rep_cd == 1);
            fs_cnt = fs_req ? fs_cnt + 1 : 0;
            fe_cnt = fe_req ? fe_cnt + 1 : 0;
            fs_ack = (fs_cnt == 3) || rep_done;
            fe_ack = (fe_cnt == 2) || rep_done;
            if (acc0) n0++;
            if (acc1) n1++;
            if (!s0_tvalid || acc0) s0_tvalid = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
            if (!s1_tvalid || acc1) s1_tvalid = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
            s0_tdata = 16'h1000 + 16'(n0);
            s1_tdata = 16'hA000 + 16'(n1);
            s0_tlast = ((n0 % WPL) == WPL - 1);
            s1_tlast = ((n1 % WPL) == WPL - 1) || (inject && (n1 % WPL) == 5);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_fc(input int target, input string name);
        int t = 0;
        while (int'(frame_count) != target && t < LIMIT) begin tick(); t++; end
        chk({"wait_", name}, t < LIMIT, 1);
    endtask

    task automatic wait_li(input int target, input string name);
        int t = 0;
        while (li != target && t < LIMIT) begin tick(); t++; end
        chk({"wait_", name}, t < LIMIT, 1);
    endtask

    task automatic wait_beat(input string name);
        int t = 0;
        int snap = beats;
        while (beats == snap && t < LIMIT) begin tick(); t++; end
        chk({"wait_", name}, t < LIMIT, 1);
    endtask

    initial begin
        int t;
        int snap;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ctrl", {fs_req, fe_req, busy, len_err, src_active, m_tvalid, m_tlast, m_tuser, s0_tready, s1_tready}, 0);
        chk("rst_frame_count", frame_count, 0);
        chk("rst_tdata", m_tdata, 0);
        tick();
        rst_n = 1'b1;
        enable = 1'b1;
        src_sel = 1'b0;

        // Nominal frame from the live source.
        wait_fc(1, "frame1");
        chk("f1_fs_rises", fs_rises, 1);
        chk("f1_fe_rises", fe_rises, 1);
        chk("f1_beats", beats, 32);
        chk("f1_tuser_cnt", tuser_cnt, 1);
        chk("f1_tlast_cnt", tlast_cnt, 4);
        chk("f1_last_data", last_data, 16'h101F);
        chk("f1_line_gap", line_gap_first, 4);

        // Backpressure on the sink plus bursty source valid.
        rnd_mode = 1'b1;
        wait_fc(2, "frame2");
        rnd_mode = 1'b0;
        chk("f2_beats", beats, 64);
        chk("f2_tlast_cnt", tlast_cnt, 8);
        chk("f2_last_data", last_data, 16'h103F);
        chk("f1_frame_gap", frame_gap_first, 7);
        chk("f2_len_err_cnt", len_err_cnt, 0);

        // Source switch mid-frame takes effect only at the next frame start.
        wait_li(1, "f3_line1");
        src_sel = 1'b1;
        repeat (5) tick();
        chk("f3_src_hold", src_active, 0);
        wait_fc(3, "frame3");
        inject = 1'b1;
        snap = len_err_cnt;
        wait_beat("f4_first");
        chk("f4_src_active", src_active, 1);
        chk("f4_first_data", last_data, 16'hA000);
        chk("f4_first_tuser", last_tuser, 1);

        // Every pattern line carries an early tlast at beat 5.
        wait_fc(4, "frame4");
        inject = 1'b0;
        chk("f4_len_err_cnt", len_err_cnt - snap, 4);
        chk("f4_beats", beats, 128);
        chk("f4_tlast_cnt", tlast_cnt, 16);

        // Disable during line 2: the frame still completes.
        wait_li(2, "f5_line2");
        enable = 1'b0;
        t = 0;
        while (busy && t < LIMIT) begin tick(); t++; end
        chk("wait_f5_idle", t < LIMIT, 1);
        chk("f5_frame_count", frame_count, 5);
        chk("f5_fe_rises", fe_rises, 5);
        chk("f5_beats", beats, 160);
        snap = fs_rises;
        repeat (30) tick();
        chk("f5_idle_busy", busy, 0);
        chk("f5_no_new_frame", fs_rises, snap);

        // Reset while waiting for the repeater.
        src_sel = 1'b0;
        enable = 1'b1;
        t = 0;
        while (rep_cd == 0 && t < LIMIT) begin tick(); t++; end
        chk("wait_f6_wait_rep", t < LIMIT, 1);
        repeat (3) tick();
        chk("f6_busy_before_rst", busy, 1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("f6_rst_ctrl", {fs_req, fe_req, busy, len_err, src_active, m_tvalid, m_tlast, m_tuser, s0_tready, s1_tready}, 0);
        chk("f6_rst_frame_count", frame_count, 0);
        chk("f6_rst_tdata", m_tdata, 0);
        tick();
        tick();
        snap = fs_rises;
        rst_n = 1'b1;
        t = 0;
        while (fs_rises == snap && t < LIMIT) begin tick(); t++; end
        chk("wait_f6_fs", t < LIMIT, 1);
        chk("f6_fs_req", fs_req, 1);
        wait_beat("f6_first");
        chk("f6_first_tuser", last_tuser, 1);
        wait_fc(1, "frame6");
        chk("f6_frame_count", frame_count, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
